// File: rtl/pipelined_segment_adder_if.sv
// Operand/result handshake bundle for pipelined_segment_adder.
// The sub signal and its modport entries exist only when ADD_SUB_EN is defined.
interface pipelined_segment_adder_if #(
    parameter int NUMBITS = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [NUMBITS-1:0] A;
    logic [NUMBITS-1:0] B;
    logic               carryin;
`ifdef ADD_SUB_EN
    logic               sub;
`endif
    logic               out_valid;
    logic               out_ready;
    logic [NUMBITS-1:0] result;
    logic               carryout;
    logic               overflow;

`ifdef ADD_SUB_EN
    modport master (output in_valid, A, B, carryin, sub, out_ready,
                    input  in_ready, out_valid, result, carryout, overflow);
    modport slave  (input  in_valid, A, B, carryin, sub, out_ready,
                    output in_ready, out_valid, result, carryout, overflow);
`else
    modport master (output in_valid, A, B, carryin, out_ready,
                    input  in_ready, out_valid, result, carryout, overflow);
    modport slave  (input  in_valid, A, B, carryin, out_ready,
                    output in_ready, out_valid, result, carryout, overflow);
`endif
endinterface

// File: rtl/pipelined_segment_adder.sv
// Pipelined segment adder: one SEGBITS slice per stage, carry registered between stages,
// valid/ready flow control with collapsing bubbles. Optional subtract mode via ADD_SUB_EN.
module pipelined_segment_adder #(
    parameter int NUMBITS = 8,
    parameter int SEGBITS = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    pipelined_segment_adder_if.slave bus
);
    localparam int STAGES = NUMBITS / SEGBITS;
    localparam int MSB    = NUMBITS - 1;
    localparam logic [NUMBITS-1:0] SEG_MASK = NUMBITS'({SEGBITS{1'b1}});

    if ((NUMBITS % SEGBITS) != 0 || STAGES < 1) begin : g_param_check
        $error("pipelined_segment_adder: NUMBITS must be a positive multiple of SEGBITS");
    end

    function automatic logic [SEGBITS:0] seg_add(input logic [SEGBITS-1:0] a,
                                                 input logic [SEGBITS-1:0] b,
                                                 input logic               cin);
        seg_add = {1'b0, a} + {1'b0, b} + {{SEGBITS{1'b0}}, cin};
    endfunction

    // Carry into the MSB is a^b^sum at that bit; overflow compares it with the carry out.
    function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                        input logic sum_msb, input logic cout);
        signed_ovf = a_msb ^ b_msb ^ sum_msb ^ cout;
    endfunction

    logic [STAGES-1:0]  v_r;
    logic [STAGES-1:0]  c_r;
    logic [NUMBITS-1:0] a_r   [STAGES];
    logic [NUMBITS-1:0] b_r   [STAGES];
    logic [NUMBITS-1:0] sum_r [STAGES];
    logic               ovf_r;

    logic [STAGES-1:0]  rdy_s;
    logic [STAGES-1:0]  vin_s;
    logic [STAGES-1:0]  cin_s;
    logic [NUMBITS-1:0] a_in_s   [STAGES];
    logic [NUMBITS-1:0] b_in_s   [STAGES];
    logic [NUMBITS-1:0] sum_in_s [STAGES];
    logic [NUMBITS-1:0] sum_nx_s [STAGES];
    logic [SEGBITS:0]   seg_s    [STAGES];
    logic               ovf_nx_s;
    logic               sub_s;

`ifdef ADD_SUB_EN
    assign sub_s = bus.sub;
`else
    assign sub_s = 1'b0;
`endif

    // A stage may load when it, or any stage downstream of it, is empty or the consumer takes.
    always_comb begin
        logic full_v;
        full_v = 1'b1;
        for (int i = STAGES - 1; i >= 0; i--) begin
            full_v   = full_v & v_r[i];
            rdy_s[i] = bus.out_ready | ~full_v;
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int LO = k * SEGBITS;

        // Subtraction inverts B once at entry; the inverted operand then travels down the pipe.
        if (k == 0) begin : g_first
            assign vin_s[k]    = bus.in_valid;
            assign a_in_s[k]   = bus.A;
            assign b_in_s[k]   = sub_s ? ~bus.B : bus.B;
            assign cin_s[k]    = sub_s ? 1'b1 : bus.carryin;
            assign sum_in_s[k] = '0;
        end else begin : g_next
            assign vin_s[k]    = v_r[k-1];
            assign a_in_s[k]   = a_r[k-1];
            assign b_in_s[k]   = b_r[k-1];
            assign cin_s[k]    = c_r[k-1];
            assign sum_in_s[k] = sum_r[k-1];
        end

        assign seg_s[k]    = seg_add(a_in_s[k][LO +: SEGBITS], b_in_s[k][LO +: SEGBITS], cin_s[k]);
        assign sum_nx_s[k] = (sum_in_s[k] & ~(SEG_MASK << LO))
                           | (NUMBITS'(seg_s[k][SEGBITS-1:0]) << LO);

        if (k == STAGES - 1) begin : g_last
            assign ovf_nx_s = signed_ovf(a_in_s[k][MSB], b_in_s[k][MSB],
                                         sum_nx_s[k][MSB], seg_s[k][SEGBITS]);
        end

        // Stage register: advance on ready, load data only for a valid operation.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                v_r[k]   <= 1'b0;
                c_r[k]   <= 1'b0;
                a_r[k]   <= '0;
                b_r[k]   <= '0;
                sum_r[k] <= '0;
            end else if (rdy_s[k]) begin
                v_r[k] <= vin_s[k];
                if (vin_s[k]) begin
                    c_r[k]   <= seg_s[k][SEGBITS];
                    a_r[k]   <= a_in_s[k];
                    b_r[k]   <= b_in_s[k];
                    sum_r[k] <= sum_nx_s[k];
                end
            end
        end
    end

    // Overflow flag registered alongside the final stage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (rdy_s[STAGES-1] && vin_s[STAGES-1]) begin
            ovf_r <= ovf_nx_s;
        end
    end

    assign bus.in_ready  = rdy_s[0];
    assign bus.out_valid = v_r[STAGES-1];
    assign bus.result    = sum_r[STAGES-1];
    assign bus.carryout  = c_r[STAGES-1];
    assign bus.overflow  = ovf_r;
endmodule

// File: tb/tb_pipelined_segment_adder.sv
// Scoreboard bench for pipelined_segment_adder (NUMBITS=8, SEGBITS=4); subtract cases
// run when ADD_SUB_EN is defined.
module tb_pipelined_segment_adder;
    localparam int NUMBITS = 8;

    logic clk = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;
    int   pushed   = 0;
    int   popped   = 0;
    int   cyc      = 0;
    logic [9:0] exp_q[$];
    int   pop_cyc[$];

    pipelined_segment_adder_if #(.NUMBITS(NUMBITS)) bus();

    pipelined_segment_adder #(.NUMBITS(NUMBITS), .SEGBITS(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: pop the oldest expectation whenever a result transfers out.
    initial begin
        logic [9:0] e;
        forever begin
            @(negedge clk);
            if (reset && bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_result actual=%0h required=none", bus.result);
                end else begin
                    e = exp_q.pop_front();
                    popped++;
                    pop_cyc.push_back(cyc);
                    check("result",   32'(bus.result),   32'(e[9:2]));
                    check("carryout", 32'(bus.carryout), 32'(e[1]));
                    check("overflow", 32'(bus.overflow), 32'(e[0]));
                end
            end
        end
    end

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cin,
                        input logic [7:0] er, input logic ec, input logic eo);
        bit done;
        done = 1'b0;
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.B        = b;
        bus.carryin  = cin;
        for (int n = 0; n < 50 && !done; n++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                exp_q.push_back({er, ec, eo});
                pushed++;
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL send_timeout actual=not_accepted required=accepted");
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done;
        done = 1'b0;
        for (int n = 0; n < 50 && !done; n++) begin
            @(posedge clk);
            #1;
            if (exp_q.size() == 0) done = 1'b1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d required=0", exp_q.size());
        end
    endtask

    initial begin
        int base;
        reset         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = 8'h00;
        bus.B         = 8'h00;
        bus.carryin   = 1'b0;
        bus.out_ready = 1'b1;
`ifdef ADD_SUB_EN
        bus.sub       = 1'b0;
`endif
        #2;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_result",    32'(bus.result),    32'd0);
        check("rst_carryout",  32'(bus.carryout),  32'd0);
        check("rst_overflow",  32'(bus.overflow),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);

        // Latency: result valid exactly two cycles after acceptance.
        send(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
        check("lat_accept_edge", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle1", 32'(bus.out_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2", 32'(bus.out_valid), 32'd1);
        wait_drain();

        send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        wait_drain();
        send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        wait_drain();
        send(8'h12, 8'h34, 1'b1, 8'h47, 1'b0, 1'b0);
        wait_drain();

        // Back-to-back stream must emerge on consecutive cycles.
        base = pop_cyc.size();
        send(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);
        send(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0);
        send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
        send(8'hFE, 8'h01, 1'b0, 8'hFF, 1'b0, 1'b0);
        wait_drain();
        for (int i = 1; i < 4; i++) begin
            if (pop_cyc.size() > base + i)
                check("stream_gap", 32'(pop_cyc[base+i] - pop_cyc[base+i-1]), 32'd1);
            else
                check("stream_count", 32'(pop_cyc.size() - base), 32'd4);
        end

        // Backpressure: two ops fill the pipe, output held, in_ready low.
        bus.out_ready = 1'b0;
        send(8'h33, 8'h44, 1'b0, 8'h77, 1'b0, 1'b0);
        send(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
        bus.in_valid = 1'b1;
        bus.A        = 8'h01;
        bus.B        = 8'hFF;
        bus.carryin  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_in_ready",  32'(bus.in_ready),  32'd0);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_result",    32'(bus.result),    32'h77);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(8'h01, 8'hFF, 1'b1, 8'h01, 1'b1, 1'b0);
        wait_drain();
        check("stall_no_loss", 32'(popped), 32'(pushed));

        // Reset with two ops in flight drops them.
        bus.out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b0, 8'h33, 1'b0, 1'b0);
        send(8'h44, 8'h11, 1'b0, 8'h55, 1'b0, 1'b0);
        check("full_out_valid", 32'(bus.out_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_result",    32'(bus.result),    32'd0);
        exp_q.delete();
        pushed = popped;
        @(posedge clk);
        #1;
        reset         = 1'b1;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("postrst_out_valid", 32'(bus.out_valid), 32'd0);
        end
        @(posedge clk);
        #1;
        send(8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0);
        wait_drain();

`ifdef ADD_SUB_EN
        bus.sub = 1'b1;
        send(8'h05, 8'h07, 1'b0, 8'hFE, 1'b0, 1'b0);
        send(8'h80, 8'h01, 1'b0, 8'h7F, 1'b1, 1'b1);
        bus.sub = 1'b0;
        wait_drain();
`endif

        check("final_no_loss", 32'(popped), 32'(pushed));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end
endmodule
